uart_mode_ctrl: RTL and testbench

Parametrised UART mode/baud controller: host-visible mode register (oversampling, baud select, tick enable), 16-bit custom divisor latch, and status register behind the 8-bit register bus. Writes land in shadow registers and are committed to the active configuration only while the serial line is idle. Generates the `sample_tick` / `bit_tick` strobes consumed by the TX and RX datapaths.

---
 rtl/uart_mode_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_uart_mode_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_mode_ctrl
// Description : UART mode/baud controller. Host writes land in shadow
//               registers and are committed to the active configuration only
//               while the serial line is idle. Generates the oversample and
//               bit strobes used by the TX/RX datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mode_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] MDR_ADDR = 8'h04,
    parameter logic [ADDR_W-1:0] DLL_ADDR = 8'h05,
    parameter logic [ADDR_W-1:0] DLM_ADDR = 8'h06,
    parameter logic [ADDR_W-1:0] STS_ADDR = 8'h07,
    parameter int                DIV_W    = 16,
    parameter int                BASE_DIV = 26
) (
    input  logic              m_clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [7:0]        data_in,
    output logic [7:0]        rd_data,
    input  logic              line_idle,
    output logic [1:0]        osm_sel,
    output logic [2:0]        br_sel,
    output logic [DIV_W-1:0]  div_active,
    output logic              sample_tick,
    output logic              bit_tick,
    output logic              cfg_pending
);

    localparam logic [DIV_W-1:0] c_base   = DIV_W'(BASE_DIV);
    localparam logic [15:0]      c_base16 = 16'(BASE_DIV);
    localparam logic [DIV_W-1:0] c_one    = {{(DIV_W-1){1'b0}}, 1'b1};

    // Effective divisor: preset ladder or custom latch, with 0 promoted to 1
    function automatic logic [DIV_W-1:0] eff_div(input logic [2:0]  br,
                                                 input logic [15:0] cust);
        logic [DIV_W-1:0] d;
        if (br == 3'd7) begin
            d = DIV_W'(cust);
        end else begin
            d = c_base >> br;
        end
        if (d == '0) begin
            d = c_one;
        end
        return d;
    endfunction

    // Shadow (host-visible) configuration
    logic [7:0]       r_sh_mdr;
    logic [7:0]       r_dll;
    logic [7:0]       r_dlm;
    logic             r_dl_lock;
    logic             r_pend;
    // Active configuration
    logic [1:0]       r_act_osm;
    logic [2:0]       r_act_br;
    logic             r_act_ten;
    logic [DIV_W-1:0] r_div_act;
    // Tick generation
    logic [DIV_W-1:0] r_pcnt;
    logic [3:0]       r_ocnt;
    logic [7:0]       r_rd_data;

    logic             w_cfg_wr;
    logic             w_commit;
    logic [DIV_W-1:0] w_sh_div;
    logic [3:0]       w_osr_m1;
    logic             w_sample;
    logic             w_bit;
    logic [7:0]       w_rd_mux;

    assign w_cfg_wr = wr_en && ((address == MDR_ADDR) ||
                                (address == DLL_ADDR) ||
                                (address == DLM_ADDR));
    // A config write in the same cycle defers the commit so the shadow is
    // never copied while it is being modified.
    assign w_commit = r_pend && line_idle && !r_dl_lock && !w_cfg_wr;
    assign w_sh_div = eff_div(r_sh_mdr[4:2], {r_dlm, r_dll});

    // Oversampling ratio minus one for the active mode
    always_comb begin
        w_osr_m1 = 4'd15;
        case (r_act_osm)
            2'b00:   w_osr_m1 = 4'd12;
            2'b10:   w_osr_m1 = 4'd7;
            default: w_osr_m1 = 4'd15;
        endcase
    end

    assign w_sample = r_act_ten && (r_pcnt == (r_div_act - c_one));
    assign w_bit    = w_sample && (r_ocnt == w_osr_m1);

    // Read mux over shadow values and status
    always_comb begin
        w_rd_mux = 8'h00;
        if (address == MDR_ADDR) begin
            w_rd_mux = r_sh_mdr;
        end else if (address == DLL_ADDR) begin
            w_rd_mux = r_dll;
        end else if (address == DLM_ADDR) begin
            w_rd_mux = r_dlm;
        end else if (address == STS_ADDR) begin
            w_rd_mux = {6'b0, r_dl_lock, r_pend};
        end
    end

    // Shadow registers, divisor lock and pending flag
    always_ff @(posedge m_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_mdr  <= 8'h00;
            r_dll     <= c_base16[7:0];
            r_dlm     <= c_base16[15:8];
            r_dl_lock <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            if (wr_en) begin
                if (address == MDR_ADDR) begin
                    r_sh_mdr <= {data_in[7], 2'b00, data_in[4:0]};
                end else if (address == DLL_ADDR) begin
                    r_dll     <= data_in;
                    r_dl_lock <= 1'b1;
                end else if (address == DLM_ADDR) begin
                    r_dlm     <= data_in;
                    r_dl_lock <= 1'b0;
                end
            end
            if (w_cfg_wr) begin
                r_pend <= 1'b1;
            end else if (w_commit) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Copy shadow to active configuration on commit
    always_ff @(posedge m_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_act_osm <= 2'b00;
            r_act_br  <= 3'd0;
            r_act_ten <= 1'b0;
            r_div_act <= c_base;
        end else if (w_commit) begin
            r_act_osm <= r_sh_mdr[1:0];
            r_act_br  <= r_sh_mdr[4:2];
            r_act_ten <= r_sh_mdr[7];
            r_div_act <= w_sh_div;
        end
    end

    // Prescaler and oversample counters; restart from zero on every commit
    always_ff @(posedge m_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt <= '0;
            r_ocnt <= 4'd0;
        end else if (w_commit || !r_act_ten) begin
            r_pcnt <= '0;
            r_ocnt <= 4'd0;
        end else if (w_sample) begin
            r_pcnt <= '0;
            r_ocnt <= (r_ocnt == w_osr_m1) ? 4'd0 : r_ocnt + 4'd1;
        end else begin
            r_pcnt <= r_pcnt + c_one;
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge m_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= 8'h00;
        end else if (rd_en) begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data     = r_rd_data;
    assign osm_sel     = r_act_osm;
    assign br_sel      = r_act_br;
    assign div_active  = r_div_act;
    assign sample_tick = w_sample;
    assign bit_tick    = w_bit;
    assign cfg_pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_uart_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mode_ctrl
// Description : Scoreboard bench for uart_mode_ctrl. Stimulus pushes expected
//               snapshots, read data and tick periods; a negedge monitor pops
//               and compares them as the DUT presents outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mode_ctrl;

    localparam logic [7:0] c_mdr = 8'h04;
    localparam logic [7:0] c_dll = 8'h05;
    localparam logic [7:0] c_dlm = 8'h06;
    localparam logic [7:0] c_sts = 8'h07;

    logic        m_clk = 1'b0;
    logic        reset_n;
    logic [7:0]  address;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  data_in;
    logic [7:0]  rd_data;
    logic        line_idle;
    logic [1:0]  osm_sel;
    logic [2:0]  br_sel;
    logic [15:0] div_active;
    logic        sample_tick;
    logic        bit_tick;
    logic        cfg_pending;

    always #5 m_clk = ~m_clk;

    uart_mode_ctrl dut (
        .m_clk       (m_clk),
        .reset_n     (reset_n),
        .address     (address),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_in     (data_in),
        .rd_data     (rd_data),
        .line_idle   (line_idle),
        .osm_sel     (osm_sel),
        .br_sel      (br_sel),
        .div_active  (div_active),
        .sample_tick (sample_tick),
        .bit_tick    (bit_tick),
        .cfg_pending (cfg_pending)
    );

    // Expected output snapshot; negative tick/rd fields mean "don't care"
    typedef struct {
        logic [1:0]  osm;
        logic [2:0]  br;
        logic [15:0] div;
        logic        pend;
        int          st;
        int          bt;
        int          rdv;
    } snap_t;

    snap_t      snap_q[$];
    logic [7:0] rd_q[$];
    int         sp_q[$];
    int         bp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: one snapshot per cycle, read data after rd_en, tick periods
    initial begin
        snap_t s;
        int    cyc    = 0;
        int    last_s = 0;
        int    last_b = 0;
        logic  rd_armed = 1'b0;
        forever begin
            @(negedge m_clk);
            cyc++;
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                check("osm_sel",     32'(osm_sel),     32'(s.osm));
                check("br_sel",      32'(br_sel),      32'(s.br));
                check("div_active",  32'(div_active),  32'(s.div));
                check("cfg_pending", 32'(cfg_pending), 32'(s.pend));
                if (s.st >= 0)  check("sample_tick", 32'(sample_tick), 32'(s.st));
                if (s.bt >= 0)  check("bit_tick",    32'(bit_tick),    32'(s.bt));
                if (s.rdv >= 0) check("rd_data_hold", 32'(rd_data),   32'(s.rdv));
            end
            if (rd_armed && rd_q.size() > 0) begin
                check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
            rd_armed = rd_en;
            if (sample_tick) begin
                if (sp_q.size() > 0) check("sample_period", 32'(cyc - last_s), 32'(sp_q.pop_front()));
                last_s = cyc;
            end
            if (bit_tick) begin
                if (bp_q.size() > 0) check("bit_period", 32'(cyc - last_b), 32'(bp_q.pop_front()));
                last_b = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge m_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        wr_en   = 1'b1;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        address = a;
        rd_en   = 1'b1;
        rd_q.push_back(e);
        tick(1);
        rd_en   = 1'b0;
    endtask

    task automatic snap(input logic [1:0] osm, input logic [2:0] br,
                        input logic [15:0] div, input logic pend,
                        input int st, input int bt, input int rdv);
        snap_t s;
        s.osm = osm; s.br = br; s.div = div; s.pend = pend;
        s.st = st; s.bt = bt; s.rdv = rdv;
        snap_q.push_back(s);
        tick(1);
    endtask

    // Wait, bounded, until the monitor has consumed every expectation
    task automatic drain();
        int k = 0;
        while ((snap_q.size() + rd_q.size() + sp_q.size() + bp_q.size()) != 0 && k < 1500) begin
            tick(1);
            k++;
        end
        check("drain_timeout", 32'(snap_q.size() + rd_q.size() + sp_q.size() + bp_q.size()), 32'd0);
        snap_q.delete(); rd_q.delete(); sp_q.delete(); bp_q.delete();
    endtask

    task automatic period(input int sp, input int bp);
        sp_q.push_back(sp);
        bp_q.push_back(bp);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        address = 8'h00; data_in = 8'h00; line_idle = 1'b1;
        tick(3);
        reset_n = 1'b1;

        // Reset state
        snap(2'd0, 3'd0, 16'd26, 1'b0, 0, 0, 0);
        rd(c_sts, 8'h00);
        rd(c_dll, 8'h1A);
        rd(c_dlm, 8'h00);
        rd(c_mdr, 8'h00);
        rd(8'h20, 8'h00);
        drain();

        // MDR=0x80: 13X, div 26, ticks on
        wr(c_mdr, 8'h80);
        snap(2'd0, 3'd0, 16'd26, 1'b1, 0, 0, -1);
        snap(2'd0, 3'd0, 16'd26, 1'b0, 0, 0, -1);
        tick(700);
        period(26, 338);
        rd(c_mdr, 8'h80);
        drain();

        // MDR=0x85: 16X, div 13
        wr(c_mdr, 8'h85);
        tick(1);
        snap(2'd1, 3'd1, 16'd13, 1'b0, -1, -1, -1);
        tick(500);
        period(13, 208);

        // Commit held off while line busy; old config keeps ticking
        line_idle = 1'b0;
        wr(c_mdr, 8'h88);
        tick(3);
        snap(2'd1, 3'd1, 16'd13, 1'b1, -1, -1, -1);
        rd(c_sts, 8'h01);
        tick(500);
        period(13, 208);
        snap(2'd1, 3'd1, 16'd13, 1'b1, -1, -1, -1);
        line_idle = 1'b1;
        tick(1);
        for (int k = 0; k < 6; k++) begin
            snap(2'd0, 3'd2, 16'd6, 1'b0, (k == 5) ? 1 : 0, 0, -1);
        end
        tick(300);
        period(6, 78);

        // Divisor lock: DLL without DLM blocks the commit
        wr(c_mdr, 8'h9C);
        wr(c_dll, 8'h00);
        snap(2'd0, 3'd2, 16'd6, 1'b1, -1, -1, -1);
        rd(c_sts, 8'h03);
        tick(2);
        snap(2'd0, 3'd2, 16'd6, 1'b1, -1, -1, -1);
        wr(c_dlm, 8'h00);
        snap(2'd0, 3'd2, 16'd6, 1'b1, -1, -1, -1);
        snap(2'd0, 3'd7, 16'd1, 1'b0, 1, 0, -1);
        snap(2'd0, 3'd7, 16'd1, 1'b0, 1, 0, -1);
        rd(c_sts, 8'h00);
        tick(50);
        period(1, 13);

        // Custom div 5, 8X, ticks disabled
        wr(c_dll, 8'h05);
        wr(c_dlm, 8'h00);
        wr(c_mdr, 8'h1E);
        snap(2'd0, 3'd7, 16'd1, 1'b1, -1, -1, -1);
        for (int k = 0; k < 8; k++) begin
            snap(2'd2, 3'd7, 16'd5, 1'b0, 0, 0, -1);
        end
        rd(c_mdr, 8'h1E);
        rd(c_dll, 8'h05);
        rd(c_sts, 8'h00);
        drain();

        // Reset while a commit is pending and ticks are running
        wr(c_mdr, 8'h80);
        tick(2);
        snap(2'd0, 3'd0, 16'd26, 1'b0, -1, -1, -1);
        line_idle = 1'b0;
        wr(c_mdr, 8'h85);
        rd(c_mdr, 8'h85);
        tick(40);
        snap(2'd0, 3'd0, 16'd26, 1'b1, -1, -1, 8'h85);
        #1;
        reset_n = 1'b0;
        snap(2'd0, 3'd0, 16'd26, 1'b0, 0, 0, 0);
        tick(2);
        reset_n   = 1'b1;
        line_idle = 1'b1;
        snap(2'd0, 3'd0, 16'd26, 1'b0, 0, 0, 0);
        rd(c_mdr, 8'h00);
        rd(c_sts, 8'h00);
        tick(30);
        snap(2'd0, 3'd0, 16'd26, 1'b0, 0, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
